// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detection, IDLE/RUN/PAUSE/EXPIRED
// state machine, tenth-second tick prescaler and display flash timing.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int FLASH_DIV = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       mode_down,
    input  logic       zero_flag,
    input  logic       max_flag,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       cnt_clear,
    output logic       lap_latch,
    output logic       lap_hold,
    output logic       blank,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_STOP,
        EV_START,
        EV_LAP
    } event_t;

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int FW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    state_t        state_r;
    logic [PW-1:0] presc;
    logic [FW-1:0] flash_cnt;
    logic          btn_start_q, btn_stop_q, btn_clear_q, btn_lap_q;
    event_t        ev;
    logic          tick;

    assign state = state_r;

    // Only the highest-priority rising edge of the cycle survives.
    always_comb begin
        ev = EV_NONE;
        if (btn_clear & ~btn_clear_q)
            ev = EV_CLEAR;
        else if (btn_stop & ~btn_stop_q)
            ev = EV_STOP;
        else if (btn_start & ~btn_start_q)
            ev = EV_START;
        else if (btn_lap & ~btn_lap_q)
            ev = EV_LAP;
    end

    assign tick = (state_r == RUN) && (presc == PRESC_LAST);

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values of each other, exactly like flip-flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Edge registers start high so a button held through reset
            // must be released and pressed again to count.
            btn_start_q <= 1'b1;
            btn_stop_q  <= 1'b1;
            btn_clear_q <= 1'b1;
            btn_lap_q   <= 1'b1;
            state_r     <= IDLE;
            presc       <= '0;
            flash_cnt   <= '0;
            cnt_en      <= 1'b0;
            cnt_dir     <= 1'b0;
            cnt_clear   <= 1'b0;
            lap_latch   <= 1'b0;
            lap_hold    <= 1'b0;
            blank       <= 1'b0;
        end else begin
            btn_start_q <= btn_start;
            btn_stop_q  <= btn_stop;
            btn_clear_q <= btn_clear;
            btn_lap_q   <= btn_lap;

            cnt_en    <= 1'b0;
            cnt_clear <= 1'b0;
            lap_latch <= 1'b0;

            if (ev == EV_CLEAR) begin
                state_r   <= IDLE;
                cnt_clear <= 1'b1;
                presc     <= '0;
                flash_cnt <= '0;
                lap_hold  <= 1'b0;
                blank     <= 1'b0;
            end else begin
                unique case (state_r)
                    IDLE: begin
                        if (ev == EV_START && !(mode_down && zero_flag)) begin
                            state_r <= RUN;
                            cnt_dir <= mode_down;
                            presc   <= '0;
                        end
                    end

                    RUN: begin
                        // The stop cycle still counts as a RUN cycle, so the
                        // prescaler advances before it is frozen in PAUSE.
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick && cnt_dir && zero_flag) begin
                            state_r   <= EXPIRED;
                            lap_hold  <= 1'b0;
                            blank     <= 1'b1;
                            flash_cnt <= '0;
                        end else begin
                            if (tick) begin
                                if (!cnt_dir && max_flag)
                                    state_r <= PAUSE;
                                else
                                    cnt_en <= 1'b1;
                            end
                            if (ev == EV_STOP) begin
                                state_r <= PAUSE;
                            end else if (ev == EV_LAP) begin
                                lap_hold  <= ~lap_hold;
                                lap_latch <= ~lap_hold;
                            end
                        end
                    end

                    PAUSE: begin
                        if (ev == EV_START)
                            state_r <= RUN;
                        else if (ev == EV_LAP && lap_hold)
                            lap_hold <= 1'b0;
                    end

                    EXPIRED: begin
                        if (flash_cnt == FLASH_LAST) begin
                            flash_cnt <= '0;
                            blank     <= ~blank;
                        end else begin
                            flash_cnt <= flash_cnt + 1'b1;
                        end
                    end

                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule
